ctrl_sequencer: RTL and testbench
=================================

CTRL_SEQUENCER -- requirements
Module: ctrl_sequencer

Interface
REQ-001 Parameter OPW, default 5: opcode width; opcode values are taken from the OP_* defines.
REQ-002 Parameter PC_WORDS, default 2: number of stack words pushed by CALL and popped by RET/RTI; legal range 1..4.
REQ-003 Parameter CNT_W, default 2: width of the word and flush counters.
REQ-004 Parameter RET_FLUSH, default 2: bubbles issued after the last RET pop; legal range 0..2^CNT_W-1.
REQ-005 Parameter RTI_FLUSH, default 3: bubbles issued after the last RTI pop; legal range 0..2^CNT_W-1.
REQ-006 Port clk, input, 1: the single clock; all state updates on its rising edge.
REQ-007 Port rst_n, input, 1: reset, asynchronous, active-low.
REQ-008 Port opcode, input, OPW: opcode of the instruction in decode.
REQ-009 Port nop_in, input, 1: hazard bubble request.
REQ-010 Port stall, input, 1: pipeline freeze.
REQ-011 Port ctrl, output, 10: {IR,IW,MR,MW,MTR,ALU_src,RW,Branch,SetC,CLRC}.
REQ-012 Port alu_op, output, 4: ALU_* code.
REQ-013 Port shift, output, 1: 1 for SHL/SHR.
REQ-014 Port push_pop, output, 2: 00 none, 01 push, 11 pop.
REQ-015 Port imm_phase, output, 1: second (immediate) cycle of LDM.
REQ-016 Port word_idx, output, CNT_W: stack word currently moved by CALL/RET/RTI; 0 is the first word.
REQ-017 Port pc_hold, output, 1: hold PC / suppress fetch advance.
REQ-018 Port busy, output, 1: state is not IDLE.

Function
REQ-019 The block SHALL hold the state register in one of IDLE, LDM2, CALL, RET, RTI or FLUSH, plus a word counter and a flush counter, each CNT_W wide.
REQ-020 All outputs SHALL be combinational functions of the state, the counters, opcode, nop_in and stall; the NOP output set is ctrl=0, alu_op=ALU_NOP, shift=0, push_pop=00, imm_phase=0, pc_hold=0.
REQ-021 With stall=1, the block SHALL drive the NOP output set except that pc_hold=1; state and counters SHALL hold.
REQ-022 In IDLE with nop_in=1, the block SHALL drive the NOP output set and remain in IDLE.
REQ-023 Outside IDLE, nop_in SHALL be ignored.
REQ-024 In IDLE, single-cycle opcodes SHALL decode in one cycle and the state SHALL remain IDLE.
REQ-025 The ALU class (NOT, INC, DEC, MOV, ADD, SUB, AND, OR, SHL, SHR) SHALL drive ctrl=ALU_SIGNALS with the matching ALU_* code, and shift=1 only for SHL and SHR.
REQ-026 PUSH SHALL drive ctrl=0001000000, alu_op=MOV, push_pop=01.
REQ-027 POP SHALL drive ctrl=0010101000, alu_op=MOV, push_pop=11.
REQ-028 LDD SHALL drive ctrl=0010101000, alu_op=LDD.
REQ-029 STD SHALL drive ctrl=0001000000, alu_op=STD.
REQ-030 JZ, JN, JC and JMP SHALL drive ctrl=BRANCH_SIGNALS, alu_op=JMP.
REQ-031 OUT SHALL drive ctrl=0100000000, alu_op=MOV.
REQ-032 IN SHALL drive ctrl=1000001000, alu_op=MOV.
REQ-033 SETC SHALL drive ctrl=0000000010, alu_op=SETC.
REQ-034 CLRC SHALL drive ctrl=0000000001, alu_op=NOP.
REQ-035 INT SHALL drive ctrl=0001000100, alu_op=NOP.
REQ-036 NOP, RST and any undefined opcode SHALL drive the NOP output set.
REQ-037 LDM in IDLE SHALL drive the NOP output set and go to LDM2.
REQ-038 LDM2 SHALL ignore opcode, drive ctrl=0000011000, alu_op=MOV, imm_phase=1, and return to IDLE.
REQ-039 CALL in IDLE SHALL drive ctrl=0001000000, alu_op=JMP, push_pop=01, word_idx=0.
REQ-040 After the first CALL cycle, the block SHALL go to CALL when PC_WORDS>1 and to IDLE otherwise.
REQ-041 Each CALL-state cycle SHALL drive ctrl=0001000000, alu_op=NOP, push_pop=01, pc_hold=1, and word_idx equal to the word counter.
REQ-042 The CALL state SHALL exit to IDLE after word PC_WORDS-1 has been pushed.
REQ-043 RET in IDLE SHALL enter RET; RTI in IDLE SHALL drive ctrl=BRANCH_SIGNALS for that cycle and enter RTI.
REQ-044 RET and RTI states SHALL each last PC_WORDS cycles and drive ctrl=0010000000, alu_op=MOV, push_pop=11, pc_hold=1, word_idx 0..PC_WORDS-1.
REQ-045 After the last pop, the block SHALL load the flush counter with RET_FLUSH or RTI_FLUSH and enter FLUSH; when that value is 0 it SHALL enter IDLE instead.
REQ-046 FLUSH SHALL drive the NOP output set with pc_hold=1, decrement the flush counter each cycle, and exit to IDLE on the cycle the counter equals 1.
REQ-047 While busy=1, opcode SHALL NOT start a new sequence.
REQ-048 Counters SHALL never wrap: parameter values beyond the counter range are illegal and SHALL be rejected at elaboration.

Reset
REQ-049 When rst_n=0, state SHALL become IDLE and both counters 0, immediately and independent of clk, aborting any sequence in progress.
REQ-050 During reset, outputs SHALL equal the NOP output set for opcode NOP, with busy=0.
REQ-051 The first instruction SHALL be decoded on the first rising edge after rst_n rises.

Verification
REQ-052 ADD then SHL in IDLE -> ctrl=ALU_SIGNALS, alu_op=ADD then SHL, shift=0 then 1, busy=0 throughout.
REQ-053 LDM followed by immediate word 0x1F -> cycle 1 NOP set; cycle 2 ctrl=0000011000, imm_phase=1; then IDLE.
REQ-054 CALL with PC_WORDS=2 -> cycle 1 push word_idx=0 alu JMP; cycle 2 push word_idx=1 pc_hold=1; then IDLE.
REQ-055 RTI with defaults -> pops at word_idx=0 and 1, then 3 FLUSH cycles with pc_hold=1, then IDLE; stall=1 for 2 cycles mid-FLUSH extends the sequence by exactly 2 cycles.
REQ-056 RET, with rst_n pulled low in the second FLUSH cycle -> busy=0 and the NOP set immediately; a following ADD decodes normally.
REQ-057 nop_in=1 during the RET pop cycles -> ignored, sequence unchanged; nop_in=1 in IDLE with opcode ADD -> NOP set.

Source files
------------

// File: rtl/ctrl_sequencer.sv
// Instruction-decode control sequencer: single-cycle decode in IDLE plus
// multi-cycle LDM, CALL, RET/RTI stack sequences and post-return flush bubbles.
module ctrl_sequencer #(
    parameter int OPW       = 5,
    parameter int PC_WORDS  = 2,
    parameter int CNT_W     = 2,
    parameter int RET_FLUSH = 2,
    parameter int RTI_FLUSH = 3
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [OPW-1:0]   opcode_i,
    input  logic             nop_in_i,
    input  logic             stall_i,
    output logic [9:0]       ctrl_o,
    output logic [3:0]       alu_op_o,
    output logic             shift_o,
    output logic [1:0]       push_pop_o,
    output logic             imm_phase_o,
    output logic [CNT_W-1:0] word_idx_o,
    output logic             pc_hold_o,
    output logic             busy_o
);

    localparam int CNT_MAX = (1 << CNT_W) - 1;

    if (OPW < 5 || PC_WORDS < 1 || PC_WORDS > 4 || PC_WORDS - 1 > CNT_MAX ||
        RET_FLUSH < 0 || RET_FLUSH > CNT_MAX || RTI_FLUSH < 0 || RTI_FLUSH > CNT_MAX) begin : g_param_err
        $error("ctrl_sequencer: parameter out of legal range");
    end

    localparam logic [OPW-1:0] OP_NOP  = OPW'(0),  OP_NOT  = OPW'(1),  OP_INC  = OPW'(2);
    localparam logic [OPW-1:0] OP_DEC  = OPW'(3),  OP_MOV  = OPW'(4),  OP_ADD  = OPW'(5);
    localparam logic [OPW-1:0] OP_SUB  = OPW'(6),  OP_AND  = OPW'(7),  OP_OR   = OPW'(8);
    localparam logic [OPW-1:0] OP_SHL  = OPW'(9),  OP_SHR  = OPW'(10), OP_PUSH = OPW'(11);
    localparam logic [OPW-1:0] OP_POP  = OPW'(12), OP_LDM  = OPW'(13), OP_LDD  = OPW'(14);
    localparam logic [OPW-1:0] OP_STD  = OPW'(15), OP_JZ   = OPW'(16), OP_JN   = OPW'(17);
    localparam logic [OPW-1:0] OP_JC   = OPW'(18), OP_JMP  = OPW'(19), OP_CALL = OPW'(20);
    localparam logic [OPW-1:0] OP_RET  = OPW'(21), OP_RTI  = OPW'(22), OP_SETC = OPW'(23);
    localparam logic [OPW-1:0] OP_CLRC = OPW'(24), OP_OUT  = OPW'(25), OP_IN   = OPW'(26);
    localparam logic [OPW-1:0] OP_INT  = OPW'(27), OP_RST  = OPW'(28);

    localparam logic [3:0] ALU_NOP = 4'd0,  ALU_NOT = 4'd1,  ALU_INC = 4'd2,  ALU_DEC  = 4'd3;
    localparam logic [3:0] ALU_MOV = 4'd4,  ALU_ADD = 4'd5,  ALU_SUB = 4'd6,  ALU_AND  = 4'd7;
    localparam logic [3:0] ALU_OR  = 4'd8,  ALU_SHL = 4'd9,  ALU_SHR = 4'd10, ALU_LDD  = 4'd11;
    localparam logic [3:0] ALU_STD = 4'd12, ALU_JMP = 4'd13, ALU_SETC = 4'd14;

    // ctrl bit order: {IR,IW,MR,MW,MTR,ALU_src,RW,Branch,SetC,CLRC}
    localparam logic [9:0] ALU_SIGNALS    = 10'b0000001000;
    localparam logic [9:0] BRANCH_SIGNALS = 10'b0000000100;

    localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(PC_WORDS - 1);
    localparam logic [CNT_W-1:0] RET_FL    = CNT_W'(RET_FLUSH);
    localparam logic [CNT_W-1:0] RTI_FL    = CNT_W'(RTI_FLUSH);

    typedef enum logic [2:0] {S_IDLE, S_LDM2, S_CALL, S_RET, S_RTI, S_FLUSH} state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] wcnt_q, wcnt_d;
    logic [CNT_W-1:0] fcnt_q, fcnt_d;
    logic [CNT_W-1:0] fl_load;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= S_IDLE;
            wcnt_q  <= '0;
            fcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            wcnt_q  <= wcnt_d;
            fcnt_q  <= fcnt_d;
        end
    end

    assign busy_o = (state_q != S_IDLE);

    always_comb begin
        state_d     = state_q;
        wcnt_d      = wcnt_q;
        fcnt_d      = fcnt_q;
        ctrl_o      = '0;
        alu_op_o    = ALU_NOP;
        shift_o     = 1'b0;
        push_pop_o  = 2'b00;
        imm_phase_o = 1'b0;
        word_idx_o  = '0;
        pc_hold_o   = 1'b0;
        fl_load     = (state_q == S_RET) ? RET_FL : RTI_FL;

        if (stall_i) begin
            pc_hold_o = 1'b1;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (!nop_in_i) begin
                        case (opcode_i)
                            OP_NOT:  begin ctrl_o = ALU_SIGNALS; alu_op_o = ALU_NOT; end
                            OP_INC:  begin ctrl_o = ALU_SIGNALS; alu_op_o = ALU_INC; end
                            OP_DEC:  begin ctrl_o = ALU_SIGNALS; alu_op_o = ALU_DEC; end
                            OP_MOV:  begin ctrl_o = ALU_SIGNALS; alu_op_o = ALU_MOV; end
                            OP_ADD:  begin ctrl_o = ALU_SIGNALS; alu_op_o = ALU_ADD; end
                            OP_SUB:  begin ctrl_o = ALU_SIGNALS; alu_op_o = ALU_SUB; end
                            OP_AND:  begin ctrl_o = ALU_SIGNALS; alu_op_o = ALU_AND; end
                            OP_OR:   begin ctrl_o = ALU_SIGNALS; alu_op_o = ALU_OR;  end
                            OP_SHL:  begin ctrl_o = ALU_SIGNALS; alu_op_o = ALU_SHL; shift_o = 1'b1; end
                            OP_SHR:  begin ctrl_o = ALU_SIGNALS; alu_op_o = ALU_SHR; shift_o = 1'b1; end
                            OP_PUSH: begin ctrl_o = 10'b0001000000; alu_op_o = ALU_MOV; push_pop_o = 2'b01; end
                            OP_POP:  begin ctrl_o = 10'b0010101000; alu_op_o = ALU_MOV; push_pop_o = 2'b11; end
                            OP_LDD:  begin ctrl_o = 10'b0010101000; alu_op_o = ALU_LDD; end
                            OP_STD:  begin ctrl_o = 10'b0001000000; alu_op_o = ALU_STD; end
                            OP_JZ, OP_JN, OP_JC, OP_JMP: begin
                                ctrl_o   = BRANCH_SIGNALS;
                                alu_op_o = ALU_JMP;
                            end
                            OP_OUT:  begin ctrl_o = 10'b0100000000; alu_op_o = ALU_MOV; end
                            OP_IN:   begin ctrl_o = 10'b1000001000; alu_op_o = ALU_MOV; end
                            OP_SETC: begin ctrl_o = 10'b0000000010; alu_op_o = ALU_SETC; end
                            OP_CLRC: ctrl_o = 10'b0000000001;
                            OP_INT:  ctrl_o = 10'b0001000100;
                            OP_LDM:  state_d = S_LDM2;
                            OP_CALL: begin
                                ctrl_o     = 10'b0001000000;
                                alu_op_o   = ALU_JMP;
                                push_pop_o = 2'b01;
                                if (PC_WORDS > 1) begin
                                    state_d = S_CALL;
                                    wcnt_d  = CNT_W'(1);
                                end
                            end
                            OP_RET: begin
                                state_d = S_RET;
                                wcnt_d  = '0;
                            end
                            OP_RTI: begin
                                ctrl_o  = BRANCH_SIGNALS;
                                state_d = S_RTI;
                                wcnt_d  = '0;
                            end
                            default: ;
                        endcase
                    end
                end
                S_LDM2: begin
                    ctrl_o      = 10'b0000011000;
                    alu_op_o    = ALU_MOV;
                    imm_phase_o = 1'b1;
                    state_d     = S_IDLE;
                end
                S_CALL: begin
                    ctrl_o     = 10'b0001000000;
                    push_pop_o = 2'b01;
                    pc_hold_o  = 1'b1;
                    word_idx_o = wcnt_q;
                    if (wcnt_q == LAST_WORD) begin
                        state_d = S_IDLE;
                        wcnt_d  = '0;
                    end else begin
                        wcnt_d = wcnt_q + 1'b1;
                    end
                end
                S_RET, S_RTI: begin
                    ctrl_o     = 10'b0010000000;
                    alu_op_o   = ALU_MOV;
                    push_pop_o = 2'b11;
                    pc_hold_o  = 1'b1;
                    word_idx_o = wcnt_q;
                    if (wcnt_q == LAST_WORD) begin
                        wcnt_d  = '0;
                        fcnt_d  = fl_load;
                        state_d = (fl_load == '0) ? S_IDLE : S_FLUSH;
                    end else begin
                        wcnt_d = wcnt_q + 1'b1;
                    end
                end
                S_FLUSH: begin
                    pc_hold_o = 1'b1;
                    fcnt_d    = fcnt_q - 1'b1;
                    // A zero count can only arise from a corrupted state; leave rather than wrap.
                    if (fcnt_q <= CNT_W'(1)) begin
                        state_d = S_IDLE;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ctrl_sequencer.sv
// Directed-vector bench for ctrl_sequencer at default parameters.
module tb_ctrl_sequencer;

    localparam logic [4:0] OP_NOP = 5'd0, OP_NOT = 5'd1, OP_INC = 5'd2, OP_DEC = 5'd3, OP_MOV = 5'd4;
    localparam logic [4:0] OP_ADD = 5'd5, OP_SUB = 5'd6, OP_AND = 5'd7, OP_OR = 5'd8, OP_SHL = 5'd9;
    localparam logic [4:0] OP_SHR = 5'd10, OP_PUSH = 5'd11, OP_POP = 5'd12, OP_LDM = 5'd13;
    localparam logic [4:0] OP_LDD = 5'd14, OP_STD = 5'd15, OP_JZ = 5'd16, OP_JN = 5'd17;
    localparam logic [4:0] OP_JC = 5'd18, OP_JMP = 5'd19, OP_CALL = 5'd20, OP_RET = 5'd21;
    localparam logic [4:0] OP_RTI = 5'd22, OP_SETC = 5'd23, OP_CLRC = 5'd24, OP_OUT = 5'd25;
    localparam logic [4:0] OP_IN = 5'd26, OP_INT = 5'd27, OP_RST = 5'd28;

    localparam logic [3:0] A_NOP = 4'd0, A_NOT = 4'd1, A_INC = 4'd2, A_DEC = 4'd3, A_MOV = 4'd4;
    localparam logic [3:0] A_ADD = 4'd5, A_SUB = 4'd6, A_AND = 4'd7, A_OR = 4'd8, A_SHL = 4'd9;
    localparam logic [3:0] A_SHR = 4'd10, A_LDD = 4'd11, A_STD = 4'd12, A_JMP = 4'd13, A_SETC = 4'd14;

    localparam logic [9:0] C_ALU = 10'b0000001000;
    localparam logic [9:0] C_BR  = 10'b0000000100;
    localparam logic [9:0] C_MW  = 10'b0001000000;
    localparam logic [9:0] C_MR  = 10'b0010000000;
    localparam logic [9:0] C_LD  = 10'b0010101000;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [4:0] opcode = OP_NOP;
    logic       nop_in = 1'b0;
    logic       stall = 1'b0;
    logic [9:0] ctrl;
    logic [3:0] alu_op;
    logic       shift;
    logic [1:0] push_pop;
    logic       imm_phase;
    logic [1:0] word_idx;
    logic       pc_hold;
    logic       busy;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    ctrl_sequencer dut (
        .clk_i(clk), .rst_ni(rst_n), .opcode_i(opcode), .nop_in_i(nop_in), .stall_i(stall),
        .ctrl_o(ctrl), .alu_op_o(alu_op), .shift_o(shift), .push_pop_o(push_pop),
        .imm_phase_o(imm_phase), .word_idx_o(word_idx), .pc_hold_o(pc_hold), .busy_o(busy)
    );

    // Packed as {busy,pc_hold,imm_phase,word_idx,push_pop,shift,alu_op,ctrl}.
    function automatic logic [21:0] pk(input logic [9:0] c, input logic [3:0] a, input logic s,
                                       input logic [1:0] pp, input logic [1:0] wi, input logic im,
                                       input logic pc, input logic bz);
        return {bz, pc, im, wi, pp, s, a, c};
    endfunction

    task automatic check(input string tag, input logic [21:0] got, input logic [21:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic apply(input logic [4:0] op, input logic nop, input logic stl);
        @(posedge clk);
        #1;
        opcode = op;
        nop_in = nop;
        stall  = stl;
        @(negedge clk);
    endtask

    task automatic step(input string tag, input logic [4:0] op, input logic nop, input logic stl,
                        input logic [21:0] exp);
        apply(op, nop, stl);
        check(tag, {busy, pc_hold, imm_phase, word_idx, push_pop, shift, alu_op, ctrl}, exp);
    endtask

    localparam logic [21:0] NOPSET = 22'd0;

    initial begin
        #12;
        check("reset_nop", {busy, pc_hold, imm_phase, word_idx, push_pop, shift, alu_op, ctrl}, NOPSET);
        @(negedge clk);
        rst_n = 1'b1;

        step("add",   OP_ADD, 0, 0, pk(C_ALU, A_ADD, 0, 2'b00, 0, 0, 0, 0));
        step("shl",   OP_SHL, 0, 0, pk(C_ALU, A_SHL, 1, 2'b00, 0, 0, 0, 0));
        step("not",   OP_NOT, 0, 0, pk(C_ALU, A_NOT, 0, 2'b00, 0, 0, 0, 0));
        step("inc",   OP_INC, 0, 0, pk(C_ALU, A_INC, 0, 2'b00, 0, 0, 0, 0));
        step("dec",   OP_DEC, 0, 0, pk(C_ALU, A_DEC, 0, 2'b00, 0, 0, 0, 0));
        step("mov",   OP_MOV, 0, 0, pk(C_ALU, A_MOV, 0, 2'b00, 0, 0, 0, 0));
        step("sub",   OP_SUB, 0, 0, pk(C_ALU, A_SUB, 0, 2'b00, 0, 0, 0, 0));
        step("and",   OP_AND, 0, 0, pk(C_ALU, A_AND, 0, 2'b00, 0, 0, 0, 0));
        step("or",    OP_OR,  0, 0, pk(C_ALU, A_OR,  0, 2'b00, 0, 0, 0, 0));
        step("shr",   OP_SHR, 0, 0, pk(C_ALU, A_SHR, 1, 2'b00, 0, 0, 0, 0));
        step("push",  OP_PUSH, 0, 0, pk(C_MW, A_MOV, 0, 2'b01, 0, 0, 0, 0));
        step("pop",   OP_POP,  0, 0, pk(C_LD, A_MOV, 0, 2'b11, 0, 0, 0, 0));
        step("ldd",   OP_LDD,  0, 0, pk(C_LD, A_LDD, 0, 2'b00, 0, 0, 0, 0));
        step("std",   OP_STD,  0, 0, pk(C_MW, A_STD, 0, 2'b00, 0, 0, 0, 0));
        step("jz",    OP_JZ,   0, 0, pk(C_BR, A_JMP, 0, 2'b00, 0, 0, 0, 0));
        step("jn",    OP_JN,   0, 0, pk(C_BR, A_JMP, 0, 2'b00, 0, 0, 0, 0));
        step("jc",    OP_JC,   0, 0, pk(C_BR, A_JMP, 0, 2'b00, 0, 0, 0, 0));
        step("jmp",   OP_JMP,  0, 0, pk(C_BR, A_JMP, 0, 2'b00, 0, 0, 0, 0));
        step("out",   OP_OUT,  0, 0, pk(10'b0100000000, A_MOV, 0, 2'b00, 0, 0, 0, 0));
        step("in",    OP_IN,   0, 0, pk(10'b1000001000, A_MOV, 0, 2'b00, 0, 0, 0, 0));
        step("setc",  OP_SETC, 0, 0, pk(10'b0000000010, A_SETC, 0, 2'b00, 0, 0, 0, 0));
        step("clrc",  OP_CLRC, 0, 0, pk(10'b0000000001, A_NOP, 0, 2'b00, 0, 0, 0, 0));
        step("int",   OP_INT,  0, 0, pk(10'b0001000100, A_NOP, 0, 2'b00, 0, 0, 0, 0));
        step("nop",   OP_NOP,  0, 0, NOPSET);
        step("rst_op", OP_RST, 0, 0, NOPSET);
        step("undef", 5'd30,   0, 0, NOPSET);

        // LDM: bubble, then immediate cycle ignoring the opcode bus
        step("ldm_c1", OP_LDM, 0, 0, NOPSET);
        step("ldm_c2", 5'h1F,  0, 0, pk(10'b0000011000, A_MOV, 0, 2'b00, 0, 1, 0, 1));
        step("ldm_end", OP_ADD, 0, 0, pk(C_ALU, A_ADD, 0, 2'b00, 0, 0, 0, 0));

        // CALL; a RET offered during the second push must not start anything
        step("call_c1", OP_CALL, 0, 0, pk(C_MW, A_JMP, 0, 2'b01, 0, 0, 0, 0));
        step("call_c2", OP_RET,  0, 0, pk(C_MW, A_NOP, 0, 2'b01, 1, 0, 1, 1));
        step("call_end", OP_ADD, 0, 0, pk(C_ALU, A_ADD, 0, 2'b00, 0, 0, 0, 0));

        // RTI with a 2-cycle stall inside the flush
        step("rti_c0",  OP_RTI, 0, 0, pk(C_BR, A_NOP, 0, 2'b00, 0, 0, 0, 0));
        step("rti_p0",  OP_NOP, 0, 0, pk(C_MR, A_MOV, 0, 2'b11, 0, 0, 1, 1));
        step("rti_p1",  OP_NOP, 0, 0, pk(C_MR, A_MOV, 0, 2'b11, 1, 0, 1, 1));
        step("rti_f1",  OP_NOP, 0, 0, pk(10'd0, A_NOP, 0, 2'b00, 0, 0, 1, 1));
        step("rti_st1", OP_ADD, 0, 1, pk(10'd0, A_NOP, 0, 2'b00, 0, 0, 1, 1));
        step("rti_st2", OP_ADD, 0, 1, pk(10'd0, A_NOP, 0, 2'b00, 0, 0, 1, 1));
        step("rti_f2",  OP_ADD, 0, 0, pk(10'd0, A_NOP, 0, 2'b00, 0, 0, 1, 1));
        step("rti_f3",  OP_ADD, 0, 0, pk(10'd0, A_NOP, 0, 2'b00, 0, 0, 1, 1));
        step("rti_end", OP_ADD, 0, 0, pk(C_ALU, A_ADD, 0, 2'b00, 0, 0, 0, 0));

        // stall in IDLE holds the instruction
        step("idle_stall", OP_SUB, 0, 1, pk(10'd0, A_NOP, 0, 2'b00, 0, 0, 1, 0));
        step("after_stall", OP_SUB, 0, 0, pk(C_ALU, A_SUB, 0, 2'b00, 0, 0, 0, 0));

        // RET with nop_in during pops, reset pulled in the second flush cycle
        step("ret_c0", OP_RET, 0, 0, NOPSET);
        step("ret_p0", OP_ADD, 1, 0, pk(C_MR, A_MOV, 0, 2'b11, 0, 0, 1, 1));
        step("ret_p1", OP_ADD, 1, 0, pk(C_MR, A_MOV, 0, 2'b11, 1, 0, 1, 1));
        step("ret_f1", OP_NOP, 0, 0, pk(10'd0, A_NOP, 0, 2'b00, 0, 0, 1, 1));
        step("ret_f2", OP_NOP, 0, 0, pk(10'd0, A_NOP, 0, 2'b00, 0, 0, 1, 1));
        #1;
        rst_n = 1'b0;
        #1;
        check("ret_abort", {busy, pc_hold, imm_phase, word_idx, push_pop, shift, alu_op, ctrl}, NOPSET);
        @(negedge clk);
        rst_n = 1'b1;
        step("post_rst_add", OP_ADD, 0, 0, pk(C_ALU, A_ADD, 0, 2'b00, 0, 0, 0, 0));

        // nop_in in IDLE suppresses decode without changing state
        step("idle_nop_in", OP_ADD, 1, 0, NOPSET);
        step("idle_ldm_nop", OP_LDM, 1, 0, NOPSET);
        step("after_nop_in", OP_ADD, 0, 0, pk(C_ALU, A_ADD, 0, 2'b00, 0, 0, 0, 0));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
